c2h_lpbk: RTL

- C2H half of the QDMA loopback: drains fixed-length packets from the loopback FIFO master side and drives them onto the QDMA C2H AXI-S stream.
- Generates per-beat CRC, per-packet C2H control fields, and one completion (CMPT) entry per packet.
- Sits between the loopback FIFO read port and the QDMA C2H stream and CMPT interfaces; the mirror of the H2C loopback receiver.

---
 rtl/c2h_lpbk_pkg.sv | 38 +++
 rtl/c2h_lpbk_if.sv | 50 +++++
 rtl/c2h_lpbk_crc32.sv | 36 +++
 rtl/c2h_lpbk.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/c2h_lpbk_pkg.sv
// Shared types and constants for the QDMA loopback C2H path.
//   state_e          : C2H sequencing states
//   CRC32_*          : CRC-32 (IEEE 802.3) constants
//   CMPT_*           : completion entry field offsets/widths
//   pkt_len_bytes()  : packet length in bytes from beat count and bus width
//   bit_reverse32()  : bit-order reversal used to build the reflected polynomial
package qdma_lpbk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    CMPT = 2'd2
  } state_e;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;

  localparam int unsigned CMPT_CNT_LSB = 0;
  localparam int unsigned CMPT_CNT_W   = 32;
  localparam int unsigned CMPT_LEN_LSB = 32;
  localparam int unsigned CMPT_LEN_W   = 16;
  localparam int unsigned CMPT_QID_LSB = 48;

  function automatic int unsigned pkt_len_bytes(input int unsigned words,
                                                input int unsigned data_width);
    return words * data_width / 8;
  endfunction

  function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/c2h_lpbk_if.sv
// Bus bundle between the loopback FIFO read port, the QDMA C2H stream and the
// QDMA CMPT interface.
//   master : the C2H engine (pops the FIFO, drives C2H stream and CMPT)
//   slave  : the surrounding FIFO/QDMA environment
interface c2h_lpbk_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CRC_WIDTH  = 32,
  parameter int unsigned QID_WIDTH  = 11,
  parameter int unsigned CMPT_WIDTH = 128
);

  logic                  fifo_m_axis_tvalid;
  logic                  fifo_m_axis_tready;
  logic [DATA_WIDTH-1:0] fifo_m_axis_tdata;
  logic                  fifo_m_axis_tlast;

  logic [DATA_WIDTH-1:0] c2h_tdata;
  logic [CRC_WIDTH-1:0]  c2h_tcrc;
  logic                  c2h_tvalid;
  logic                  c2h_tready;
  logic                  c2h_tlast;
  logic [QID_WIDTH-1:0]  c2h_ctrl_qid;
  logic [15:0]           c2h_ctrl_len;
  logic                  c2h_ctrl_has_cmpt;
  logic [5:0]            c2h_mty;

  logic [CMPT_WIDTH-1:0] c2h_cmpt_tdata;
  logic [QID_WIDTH-1:0]  c2h_cmpt_qid;
  logic                  c2h_cmpt_tvalid;
  logic                  c2h_cmpt_tready;

  modport master (
    input  fifo_m_axis_tvalid, fifo_m_axis_tdata, fifo_m_axis_tlast,
    input  c2h_tready, c2h_cmpt_tready,
    output fifo_m_axis_tready,
    output c2h_tdata, c2h_tcrc, c2h_tvalid, c2h_tlast,
    output c2h_ctrl_qid, c2h_ctrl_len, c2h_ctrl_has_cmpt, c2h_mty,
    output c2h_cmpt_tdata, c2h_cmpt_qid, c2h_cmpt_tvalid
  );

  modport slave (
    output fifo_m_axis_tvalid, fifo_m_axis_tdata, fifo_m_axis_tlast,
    output c2h_tready, c2h_cmpt_tready,
    input  fifo_m_axis_tready,
    input  c2h_tdata, c2h_tcrc, c2h_tvalid, c2h_tlast,
    input  c2h_ctrl_qid, c2h_ctrl_len, c2h_ctrl_has_cmpt, c2h_mty,
    input  c2h_cmpt_tdata, c2h_cmpt_qid, c2h_cmpt_tvalid
  );

endinterface

// File: rtl/c2h_lpbk_crc32.sv
// Combinational CRC-32 of one data beat (IEEE 802.3: init all-ones,
// reflected in/out, final inversion), bytes consumed LSB byte first.
//   data : beat to checksum
//   crc  : CRC-32 of the whole beat
module qdma_crc32_beat
  import qdma_lpbk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned CRC_WIDTH  = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic [CRC_WIDTH-1:0]  crc
);

  if (CRC_WIDTH != 32) begin : g_crc_width_chk
    $error("qdma_crc32_beat: CRC_WIDTH must be 32");
  end
  if ((DATA_WIDTH % 8) != 0) begin : g_data_width_chk
    $error("qdma_crc32_beat: DATA_WIDTH must be a whole number of bytes");
  end

  localparam logic [31:0] POLY_REFL = bit_reverse32(CRC32_POLY);

  logic [31:0] crc_acc;

  // Reflected shift-right form: walking data bits 0..N-1 feeds each byte
  // LSB first, byte 0 first, matching the reflected-input convention.
  always_comb begin
    crc_acc = CRC32_INIT;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      crc_acc = {1'b0, crc_acc[31:1]} ^ ((crc_acc[0] ^ data[i]) ? POLY_REFL : '0);
    end
    crc = CRC_WIDTH'(~crc_acc);
  end

endmodule

// File: rtl/c2h_lpbk.sv
// C2H half of the QDMA loopback: drains fixed-length packets from the loopback
// FIFO onto the QDMA C2H stream, then emits one completion entry per packet.
//   clk, rst_n    : clock, asynchronous active-low reset
//   c2h_en        : allows a new packet to start
//   c2h_qid       : target queue, sampled when a packet starts
//   c2h_pkt_done  : one-cycle pulse after each completion handshake
//   c2h_pkt_cnt   : completed packet count (wraps)
//   len_err       : sticky, FIFO tlast disagreed with the beat count
//   bus           : FIFO read port, C2H stream and CMPT signals
module c2h_lpbk
  import qdma_lpbk_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 256,
  parameter int unsigned PKT_WORDS_LEN = 8,
  parameter int unsigned CRC_WIDTH     = 32,
  parameter int unsigned QID_WIDTH     = 11,
  parameter int unsigned CMPT_WIDTH    = 128
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 c2h_en,
  input  logic [QID_WIDTH-1:0] c2h_qid,
  output logic                 c2h_pkt_done,
  output logic [31:0]          c2h_pkt_cnt,
  output logic                 len_err,
  c2h_lpbk_if.master           bus
);

  localparam int unsigned PKT_LEN_BYTES = pkt_len_bytes(PKT_WORDS_LEN, DATA_WIDTH);
  localparam int unsigned BEAT_W        = (PKT_WORDS_LEN > 1) ? $clog2(PKT_WORDS_LEN) : 1;

  if (PKT_LEN_BYTES > 65535) begin : g_len_chk
    $error("c2h_lpbk: packet length exceeds 16-bit ctrl_len");
  end
  if (PKT_WORDS_LEN < 1) begin : g_words_chk
    $error("c2h_lpbk: PKT_WORDS_LEN must be at least 1");
  end
  if (CMPT_WIDTH < CMPT_QID_LSB + QID_WIDTH) begin : g_cmpt_chk
    $error("c2h_lpbk: CMPT_WIDTH too narrow for completion fields");
  end

  state_e               state_q, state_d;
  logic [QID_WIDTH-1:0] qid_q, qid_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic                 len_err_q, len_err_d;
  logic                 pkt_done_q, pkt_done_d;

  logic                  last_beat;
  logic                  c2h_tvalid_c;
  logic                  fifo_tready_c;
  logic                  c2h_tlast_c;
  logic [DATA_WIDTH-1:0] c2h_tdata_c;
  logic                  cmpt_tvalid_c;
  logic [CMPT_WIDTH-1:0] cmpt_tdata_c;
  logic [CRC_WIDTH-1:0]  crc_raw;

  assign last_beat = (beat_q == BEAT_W'(PKT_WORDS_LEN - 1));

  always_comb begin
    state_d       = state_q;
    qid_d         = qid_q;
    beat_d        = beat_q;
    pkt_cnt_d     = pkt_cnt_q;
    len_err_d     = len_err_q;
    pkt_done_d    = 1'b0;
    c2h_tvalid_c  = 1'b0;
    fifo_tready_c = 1'b0;
    c2h_tlast_c   = 1'b0;
    c2h_tdata_c   = '0;
    cmpt_tvalid_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (c2h_en && bus.fifo_m_axis_tvalid) begin
          qid_d   = c2h_qid;
          beat_d  = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        c2h_tvalid_c  = bus.fifo_m_axis_tvalid;
        fifo_tready_c = bus.c2h_tready;
        c2h_tdata_c   = bus.fifo_m_axis_tdata;
        c2h_tlast_c   = last_beat;
        if (bus.fifo_m_axis_tvalid && bus.c2h_tready) begin
          beat_d = beat_q + BEAT_W'(1);
          // The beat counter defines the packet; FIFO tlast is only audited.
          if (bus.fifo_m_axis_tlast != last_beat) begin
            len_err_d = 1'b1;
          end
          if (last_beat) begin
            state_d = CMPT;
          end
        end
      end
      CMPT: begin
        cmpt_tvalid_c = 1'b1;
        if (bus.c2h_cmpt_tready) begin
          pkt_done_d = 1'b1;
          pkt_cnt_d  = pkt_cnt_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmpt_tdata_c = '0;
    if (state_q == CMPT) begin
      cmpt_tdata_c[CMPT_CNT_LSB +: CMPT_CNT_W] = pkt_cnt_q;
      cmpt_tdata_c[CMPT_LEN_LSB +: CMPT_LEN_W] = 16'(PKT_LEN_BYTES);
      cmpt_tdata_c[CMPT_QID_LSB +: QID_WIDTH]  = qid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      qid_q      <= '0;
      beat_q     <= '0;
      pkt_cnt_q  <= '0;
      len_err_q  <= 1'b0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      qid_q      <= qid_d;
      beat_q     <= beat_d;
      pkt_cnt_q  <= pkt_cnt_d;
      len_err_q  <= len_err_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  qdma_crc32_beat #(
    .DATA_WIDTH (DATA_WIDTH),
    .CRC_WIDTH  (CRC_WIDTH)
  ) u_crc (
    .data (c2h_tdata_c),
    .crc  (crc_raw)
  );

  assign c2h_pkt_done = pkt_done_q;
  assign c2h_pkt_cnt  = pkt_cnt_q;
  assign len_err      = len_err_q;

  assign bus.fifo_m_axis_tready = fifo_tready_c;
  assign bus.c2h_tdata          = c2h_tdata_c;
  assign bus.c2h_tcrc           = c2h_tvalid_c ? crc_raw : '0;
  assign bus.c2h_tvalid         = c2h_tvalid_c;
  assign bus.c2h_tlast          = c2h_tlast_c;
  assign bus.c2h_ctrl_qid       = qid_q;
  assign bus.c2h_ctrl_len       = 16'(PKT_LEN_BYTES);
  assign bus.c2h_ctrl_has_cmpt  = 1'b1;
  assign bus.c2h_mty            = '0;
  assign bus.c2h_cmpt_tdata     = cmpt_tdata_c;
  assign bus.c2h_cmpt_qid       = qid_q;
  assign bus.c2h_cmpt_tvalid    = cmpt_tvalid_c;

endmodule
